// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for the bit-serial adder
//
// Groups the operation request (start, a, b, cin) and the status/result
// (busy, done, s, cout) of serial_add_ctrl.
//   master : issues requests, observes status and result
//   slave  : the adder controller
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, s, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, s, cout
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sharing one full-adder cell
//
// Adds two WIDTH-bit operands plus carry-in one bit per clock, LSB first,
// keeping the running carry in a flop. The result is registered and held
// until the next operation completes.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of serial_add_ctrl_if
//             start/a/b/cin in; busy (RUN), done (one-cycle DONE), s/cout out

module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             load;
    logic             last;

    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] s_q;
    logic             cout_q;
    logic             fa_s;
    logic             fa_cout;

    fulladder u_fa (
        .a    (sa[0]),
        .b    (sb[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 is at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign acc_next = fa_s;
        end else begin : g_acc_wn
            assign acc_next = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // Accepting here gives back-to-back operation without an IDLE gap.
                if (bus.start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sa     <= '0;
            sb     <= '0;
            acc    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            s_q    <= '0;
            cout_q <= 1'b0;
        end else if (load) begin
            sa    <= bus.a;
            sb    <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_next;
            carry <= fa_cout;
            sa    <= sa >> 1;
            sb    <= sb >> 1;
            cnt   <= cnt + 1'b1;
            // Result registers only move on the final bit, so the previous
            // result stays visible throughout a new operation.
            if (last) begin
                s_q    <= acc_next;
                cout_q <= fa_cout;
            end
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial addition controller that time-shares one `fulladder` cell across a WIDTH-bit operand pair. It processes one bit per clock, LSB first, and keeps the carry in a flop between bits. It sits beside the combinational adder library as the area-minimal sequenced alternative to a ripple-carry adder. Results are registered and held stable until the next operation completes.

## Interface
- `WIDTH`, default 8: operand/sum width in bits, must be ≥ 1.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request a new addition. Sampled on a rising edge; honoured only in IDLE or DONE.
- `a`  in  WIDTH: operand A, captured when start is accepted.
- `b`  in  WIDTH: operand B, captured when start is accepted.
- `cin`  in  1: carry-in, captured when start is accepted.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse; high while in DONE.
- `s`  out  WIDTH: registered sum of the last completed operation.
- `cout`  out  1: registered carry-out of the last completed operation.

## Operation
- Exactly one `fulladder` instance (ports a, b, cin, s, cout). Its inputs are `sa[0]`, `sb[0]` and `carry`.
- Internal state: operand shift registers `sa`, `sb` (WIDTH each), `carry` flop, partial-sum shift register `acc` (WIDTH), bit counter `cnt` ($clog2(WIDTH+1) bits).
- FSM: IDLE, RUN, DONE. Moore outputs: `busy` = (state == RUN), `done` = (state == DONE).
- IDLE, start=1:
  - `sa` <= `a`, `sb` <= `b`, `carry` <= `cin`, `cnt` <= 0.
  - Go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, every edge:
  - `acc` <= {fa.s, acc[WIDTH-1:1]}.
  - `carry` <= fa.cout.
  - `sa`, `sb` shift right by 1, zero fill.
  - `cnt` <= cnt+1.
- RUN, when `cnt` == WIDTH-1 on the same edge:
  - `s` <= {fa.s, acc[WIDTH-1:1]}, `cout` <= fa.cout.
  - Go to DONE.
- RUN, start: ignored. Operands are not recaptured and no error is flagged.
- DONE, start=1: accepted exactly as in IDLE, go to RUN. This gives back-to-back operation.
- DONE, start=0: go to IDLE.
- `s` and `cout` change only on the RUN→DONE edge. They hold through IDLE and through any subsequent RUN.
- Arithmetic: {cout, s} = a + b + cin, modulo 2^(WIDTH+1). No overflow flag.
- Changes on `a`, `b`, `cin` after acceptance have no effect on the operation in flight.

## Timing
- Reset (reset_n=0, asynchronous): state=IDLE; `busy`=0, `done`=0, `s`=0, `cout`=0; `sa`, `sb`, `acc`, `carry`, `cnt` = 0.
- Reset deassertion is synchronised externally. The first accepted start is on the first rising edge with reset_n=1.
- start accepted at edge E0:
  - `busy`=1 for cycles E0..E0+WIDTH.
  - Bit k is processed at edge E0+k+1.
  - `s`/`cout` are valid and `done`=1 in the cycle after edge E0+WIDTH.
- Latency from start to done: WIDTH+1 edges.
- Throughput with start held high: one result every WIDTH+1 cycles.
- Reset asserted mid-RUN: the operation is aborted immediately. All outputs go to 0 and the previous `s`/`cout` are lost. No done pulse is produced.
- WIDTH=1: accept at E0; RUN for one edge; DONE after E0+1.

## Test plan
- WIDTH=8; a=8'h5A, b=8'h3C, cin=0, single start pulse -> busy high for 8 cycles, done pulse 9 edges after accept, s=8'h96, cout=0, busy=0 during done.
- WIDTH=8; a=8'hFF, b=8'h01, cin=0 -> s=8'h00, cout=1. Then a=8'hFF, b=8'h00, cin=1 -> s=8'h00, cout=1. Then a=8'h00, b=8'h00, cin=0 -> s=0, cout=0.
- start held high with operands changing each cycle: (12,34,0), then (200,100,1) presented during DONE -> results 46/cout0 then 45/cout1, done pulses exactly 9 cycles apart; start pulses during RUN ignored and operand changes during RUN do not affect results.
- Result hold: after done, idle 20 cycles with random a/b/cin -> s/cout unchanged. During a new RUN, s/cout still show the prior result until the new done.
- reset_n pulled low at bit 4 of a RUN -> busy, done, s, cout = 0 asynchronously, without waiting for an edge. After release, a fresh start computes correctly with no stale carry.
- WIDTH=4 exhaustive: all 512 combinations of a, b, cin -> {cout,s} == a+b+cin for each. Also run WIDTH=1, all 8 input combinations, with done 2 edges after accept.
